verify_frame_ctrl: RTL

//  Sequences the ASCII sequence checker between UART RX and UART TX. Buffers RX

---
 rtl/verify_frame_ctrl_if.sv | 25 ++
 rtl/verify_frame_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/verify_frame_ctrl_if.sv
// Byte-level links of the frame controller: UART RX in, checker out/in, UART TX out.
interface verify_frame_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] chk_char;
  logic       chk_valid;
  logic       chk_rst;
  logic       chk_seq_valid;
  logic       chk_strobe;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       frame_done;
  logic       frame_ok;
  logic [7:0] drop_cnt;

  modport slave (
    input  rx_data, rx_valid, chk_seq_valid, chk_strobe, tx_busy,
    output chk_char, chk_valid, chk_rst, tx_data, tx_start, frame_done, frame_ok, drop_cnt
  );
  modport master (
    output rx_data, rx_valid, chk_seq_valid, chk_strobe, tx_busy,
    input  chk_char, chk_valid, chk_rst, tx_data, tx_start, frame_done, frame_ok, drop_cnt
  );
endinterface

// File: rtl/verify_frame_ctrl.sv
// Buffers RX bytes, paces them into the sequence checker, tracks '$'-delimited
// frames and answers each frame with one response byte on UART TX.
module verify_frame_ctrl #(
  parameter int         FIFO_DEPTH   = 16,
  parameter int         GAP_CYCLES   = 4,
  parameter int         MAX_LEN      = 16,
  parameter int         RESP_TIMEOUT = 1024,
  parameter logic [7:0] DELIM        = 8'h24,
  parameter logic [7:0] OK_CHAR      = 8'h59,
  parameter logic [7:0] ERR_CHAR     = 8'h4E
) (
  input logic               clk,
  input logic               rst,
  verify_frame_ctrl_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(RESP_TIMEOUT - 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, EMIT, GAP, WAIT_RES, RECOVER, SEND} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, wr_en, pop, gap_done, overflow, is_delim;
  logic [7:0]    head;
  state_t        state;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] timer;
  logic [LW-1:0] len;
  logic          in_frame, end_pending, res_ok, rec_cnt;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en    = bus.rx_valid && !full;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign gap_done = (gap_cnt == GAP_LAST);
  assign is_delim = (head == DELIM);
  // Any byte inside a frame, closing delimiter included, grows the length.
  assign overflow = in_frame && (len >= LEN_MAX);
  assign pop      = !empty && (state == IDLE || (state == GAP && gap_done && !end_pending));

  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= bus.rx_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      bus.drop_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (bus.rx_valid && full && bus.drop_cnt != 8'hFF) bus.drop_cnt <= bus.drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      gap_cnt        <= '0;
      timer          <= '0;
      len            <= '0;
      in_frame       <= 1'b0;
      end_pending    <= 1'b0;
      res_ok         <= 1'b0;
      rec_cnt        <= 1'b0;
      bus.chk_char   <= '0;
      bus.chk_valid  <= 1'b0;
      bus.chk_rst    <= 1'b0;
      bus.tx_data    <= '0;
      bus.tx_start   <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_ok   <= 1'b0;
    end else begin
      bus.chk_valid  <= 1'b0;
      bus.tx_start   <= 1'b0;
      bus.frame_done <= 1'b0;
      case (state)
        IDLE: ;
        EMIT: begin
          bus.chk_valid <= 1'b1;
          gap_cnt       <= '0;
          state         <= GAP;
        end
        GAP: begin
          if (!gap_done) gap_cnt <= gap_cnt + 1'b1;
          else if (end_pending) begin
            end_pending <= 1'b0;
            timer       <= '0;
            state       <= WAIT_RES;
          end else if (empty) state <= IDLE;
        end
        WAIT_RES: begin
          if (bus.chk_strobe) begin
            res_ok <= bus.chk_seq_valid;
            state  <= SEND;
          end else if (timer == TMO_LAST) begin
            res_ok      <= 1'b0;
            bus.chk_rst <= 1'b1;
            rec_cnt     <= 1'b0;
            state       <= RECOVER;
          end else timer <= timer + 1'b1;
        end
        RECOVER: begin
          if (rec_cnt) begin
            bus.chk_rst <= 1'b0;
            in_frame    <= 1'b0;
            len         <= '0;
            end_pending <= 1'b0;
            state       <= SEND;
          end else rec_cnt <= 1'b1;
        end
        SEND: begin
          if (!bus.tx_busy) begin
            bus.tx_start   <= 1'b1;
            bus.frame_done <= 1'b1;
            bus.tx_data    <= res_ok ? OK_CHAR : ERR_CHAR;
            bus.frame_ok   <= res_ok;
            gap_cnt        <= '0;
            state          <= GAP;
          end
        end
        default: state <= IDLE;
      endcase

      // Pop decision overrides the per-state transition above.
      if (pop) begin
        if (overflow) begin
          res_ok      <= 1'b0;
          bus.chk_rst <= 1'b1;
          rec_cnt     <= 1'b0;
          state       <= RECOVER;
        end else begin
          bus.chk_char <= head;
          state        <= EMIT;
          if (in_frame) begin
            len <= len + 1'b1;
            if (is_delim) begin
              end_pending <= 1'b1;
              in_frame    <= 1'b0;
            end
          end else if (is_delim) begin
            in_frame <= 1'b1;
            len      <= LW'(1);
          end
        end
      end
    end
  end
endmodule
